cam_tx_scheduler: RTL

Arbitrates several 32-bit word requesters onto the single nibble-serial camera-port transmitter that carries FPGA-to-ESP32 traffic. Grants requesters round-robin into a small FIFO. Drains that FIFO into the serializer one word at a time, pacing writes with the serializer's busy flag so that no word is overwritten before it is loaded into the shift register.

---
 rtl/cam_tx_scheduler_if.sv | 26 ++
 rtl/cam_tx_scheduler.sv | 132 +++++++++++++
 2 files changed

// File: rtl/cam_tx_scheduler_if.sv
// Requester and serializer bundle for cam_tx_scheduler.
// The DUT connects through slave. A driver or bench connects through master.
interface cam_tx_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic [NUM_REQ-1:0]          req_valid_i;
  logic [NUM_REQ*32-1:0]       req_data_i;
  logic [NUM_REQ-1:0]          req_ready_o;
  logic                        ser_wr_o;
  logic [31:0]                 ser_data_o;
  logic                        ser_busy_i;
  logic [$clog2(FIFO_DEPTH):0] fifo_level_o;
  logic [CNT_WIDTH-1:0]        sent_count_o;

  modport master (
    output req_valid_i, req_data_i, ser_busy_i,
    input  req_ready_o, ser_wr_o, ser_data_o, fifo_level_o, sent_count_o
  );

  modport slave (
    input  req_valid_i, req_data_i, ser_busy_i,
    output req_ready_o, ser_wr_o, ser_data_o, fifo_level_o, sent_count_o
  );
endinterface

// File: rtl/cam_tx_scheduler.sv
// Round-robin arbiter feeding a word FIFO, drained one word at a time into the nibble serializer.
// Define CAM_TX_TAG_EN to replace data[31:29] with the source requester index.
module cam_tx_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input logic               clk_i,
  input logic               rst_n,
  cam_tx_scheduler_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT} state_t;

  state_t               state_reg;
  logic [IDX_W-1:0]     last_grant_reg;
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [LVL_W-1:0]     level_reg;
  logic                 ser_wr_reg;
  logic [31:0]          ser_data_reg;
  logic [CNT_WIDTH-1:0] sent_count_reg;
  logic [31:0]          mem [FIFO_DEPTH];

  logic [31:0]          req_word [NUM_REQ];
  logic                 grant_found;
  logic [IDX_W-1:0]     grant_idx;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [31:0]          push_word;

  assign full  = (level_reg == LVL_W'(FIFO_DEPTH));
  assign empty = (level_reg == '0);
  assign push  = grant_found && !full;
  assign pop   = (state_reg == IDLE) && !empty && !bus.ser_busy_i;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_word[gi]       = bus.req_data_i[32*gi +: 32];
      assign bus.req_ready_o[gi] = push && (grant_idx == IDX_W'(gi));
    end
  endgenerate

  // Search starts just after the last winner, so every requester gets a turn.
  always_comb begin : arb
    logic [IDX_W-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_grant_reg) + i) % NUM_REQ);
      if (!grant_found && bus.req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

`ifdef CAM_TX_TAG_EN
  assign push_word = {3'(grant_idx), req_word[grant_idx][28:0]};
`else
  assign push_word = req_word[grant_idx];
`endif

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_word;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      last_grant_reg <= IDX_W'(NUM_REQ - 1);
    end else begin
      if (push) begin
        wr_ptr_reg     <= wr_ptr_reg + PTR_W'(1);
        last_grant_reg <= grant_idx;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // SETTLE skips one busy sample because the serializer reports busy a cycle after the write.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      ser_wr_reg     <= 1'b0;
      ser_data_reg   <= '0;
      sent_count_reg <= '0;
    end else begin
      ser_wr_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (pop) begin
            state_reg      <= ISSUE;
            ser_wr_reg     <= 1'b1;
            ser_data_reg   <= mem[rd_ptr_reg];
            sent_count_reg <= sent_count_reg + CNT_WIDTH'(1);
          end
        end
        ISSUE:  state_reg <= SETTLE;
        SETTLE: state_reg <= WAIT;
        WAIT: begin
          if (!bus.ser_busy_i) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.ser_wr_o     = ser_wr_reg;
  assign bus.ser_data_o   = ser_data_reg;
  assign bus.fifo_level_o = level_reg;
  assign bus.sent_count_o = sent_count_reg;
endmodule
